fetch_align: RTL and testbench

FETCH_ALIGN -- requirements
Module: fetch_align

---
 rtl/fetch_align.sv | 129 ++++++++++++
 tb/tb_fetch_align.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_align.sv
// Instruction fetch/align stage: turns a word-wide, one-cycle-latency imem into an
// instruction stream. Compressed (16-bit) support is built when FETCH_RVC_EN is defined.
module fetch_align #(
  parameter int          ADDR_WIDTH = 9,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [31:0]           imem_dout,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [31:0]           redirect_pc,
  output logic                  instr_valid,
  output logic [31:0]           instr,
  output logic [31:0]           instr_pc,
  output logic                  instr_is_rvc
);

`ifdef FETCH_RVC_EN
  localparam logic [31:0] PC_MASK = 32'hFFFF_FFFE;
  typedef enum logic [1:0] {FILL, RUN, SPLIT} state_t;
`else
  localparam logic [31:0] PC_MASK = 32'hFFFF_FFFC;
  typedef enum logic [1:0] {FILL, RUN} state_t;
`endif

  state_t      state_q, state_d;
  logic [31:0] fpc_q, fpc_d, pc_next;
  logic        emit;
  logic [31:0] e_instr, e_pc;
  logic        e_rvc;
`ifdef FETCH_RVC_EN
  logic [15:0] buf_q, buf_d, h;
`endif

  always_comb begin
    state_d = state_q;
    fpc_d   = fpc_q;
    emit    = 1'b0;
    e_instr = imem_dout;
    e_pc    = fpc_q;
    e_rvc   = 1'b0;
`ifdef FETCH_RVC_EN
    buf_d   = buf_q;
    h       = fpc_q[1] ? imem_dout[31:16] : imem_dout[15:0];
`endif
    case (state_q)
      FILL: if (!stall) state_d = RUN;
      RUN: if (!stall) begin
`ifdef FETCH_RVC_EN
        if (h[1:0] != 2'b11) begin
          emit    = 1'b1;
          e_instr = {16'h0000, h};
          e_rvc   = 1'b1;
          fpc_d   = fpc_q + 32'd2;
        end else if (!fpc_q[1]) begin
          emit  = 1'b1;
          fpc_d = fpc_q + 32'd4;
        end else begin
          // Lower half of a word-spanning instruction: park it, fetch the next word.
          buf_d   = h;
          fpc_d   = fpc_q + 32'd2;
          state_d = SPLIT;
        end
`else
        emit  = 1'b1;
        fpc_d = fpc_q + 32'd4;
`endif
      end
`ifdef FETCH_RVC_EN
      SPLIT: if (!stall) begin
        // Upper half comes from this word's low half, so step past it.
        emit    = 1'b1;
        e_instr = {imem_dout[15:0], buf_q};
        e_pc    = fpc_q - 32'd2;
        fpc_d   = fpc_q + 32'd2;
        state_d = RUN;
      end
`endif
      default: state_d = FILL;
    endcase
    if (redirect) begin
      fpc_d   = redirect_pc & PC_MASK;
      state_d = FILL;
      emit    = 1'b0;
`ifdef FETCH_RVC_EN
      buf_d   = 16'h0000;
`endif
    end
  end

  assign pc_next   = rst ? (RESET_PC & PC_MASK) : fpc_d;
  assign imem_addr = pc_next[ADDR_WIDTH+1:2];

  logic unused_bits;
  assign unused_bits = ^{pc_next, redirect_pc};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FILL;
      fpc_q        <= RESET_PC & PC_MASK;
      instr_valid  <= 1'b0;
      instr        <= 32'h0;
      instr_pc     <= 32'h0;
      instr_is_rvc <= 1'b0;
`ifdef FETCH_RVC_EN
      buf_q        <= 16'h0000;
`endif
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
`ifdef FETCH_RVC_EN
      buf_q   <= buf_d;
`endif
      if (redirect) begin
        instr_valid <= 1'b0;
      end else if (!stall) begin
        instr_valid <= emit;
        if (emit) begin
          instr        <= e_instr;
          instr_pc     <= e_pc;
          instr_is_rvc <= e_rvc;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_align.sv
// Directed bench for fetch_align with a one-cycle-latency word memory model.
module tb_fetch_align;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_dout;
  logic          stall, redirect;
  logic [31:0]   redirect_pc;
  logic          instr_valid;
  logic [31:0]   instr, instr_pc;
  logic          instr_is_rvc;

  logic [31:0] mem [0:(1<<AW)-1];
  int checks = 0;
  int failures = 0;
  logic [65:0] obs, exp_v;

  fetch_align #(.ADDR_WIDTH(AW), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_dout(imem_dout),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_is_rvc(instr_is_rvc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) imem_dout <= mem[imem_addr];

  assign obs = {instr_valid, instr, instr_pc, instr_is_rvc};

  task automatic load_nops;
    for (int i = 0; i < (1<<AW); i++) mem[i] = 32'h0000_0013;
  endtask

  task automatic do_reset;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h100;
    repeat (3) @(negedge clk);
    checks++;
    if (obs !== 66'h0) begin
      failures++; $display("FAIL reset_outputs got=%h exp=0", obs);
    end
    checks++;
    if (imem_addr !== 9'd0) begin
      failures++; $display("FAIL reset_addr got=%0d exp=0", imem_addr);
    end
    stall = 1'b0; redirect = 1'b0;
  endtask

  task automatic test_sequential;
    load_nops();
    mem[0] = 32'h0050_0093; mem[1] = 32'h0010_0113;
    do_reset();
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b0) begin
      failures++; $display("FAIL seq_fill_valid got=%b exp=0", instr_valid);
    end
    @(negedge clk);
    exp_v = {1'b1, 32'h0050_0093, 32'h0, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      failures++; $display("FAIL seq_first got=%h exp=%h", obs, exp_v);
    end
    @(negedge clk);
    exp_v = {1'b1, 32'h0010_0113, 32'h4, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      failures++; $display("FAIL seq_second got=%h exp=%h", obs, exp_v);
    end
  endtask

  task automatic test_stall;
    load_nops();
    mem[0] = 32'h0010_0093; mem[1] = 32'h0020_0113; mem[2] = 32'h0030_0193;
    do_reset();
    repeat (2) @(negedge clk);
    exp_v = {1'b1, 32'h0010_0093, 32'h0, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      failures++; $display("FAIL stall_pre got=%h exp=%h", obs, exp_v);
    end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL stall_hold%0d got=%h exp=%h", i, obs, exp_v);
      end
      checks++;
      if (imem_addr !== 9'd1) begin
        failures++; $display("FAIL stall_addr%0d got=%0d exp=1", i, imem_addr);
      end
    end
    stall = 1'b0;
    @(negedge clk);
    exp_v = {1'b1, 32'h0020_0113, 32'h4, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      failures++; $display("FAIL stall_release got=%h exp=%h", obs, exp_v);
    end
    @(negedge clk);
    exp_v = {1'b1, 32'h0030_0193, 32'h8, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      failures++; $display("FAIL back_to_back got=%h exp=%h", obs, exp_v);
    end
  endtask

  task automatic test_redirect;
    load_nops();
    mem[16] = 32'h0070_0393;
`ifdef FETCH_RVC_EN
    mem[0] = {16'h0093, 16'h4501}; mem[1] = {16'h4585, 16'h0050};
    do_reset();
    repeat (3) @(negedge clk);   // FILL, RVC at 0, then entering SPLIT
    checks++;
    if (instr_valid !== 1'b0) begin
      failures++; $display("FAIL redir_in_split got=%b exp=0", instr_valid);
    end
    redirect_pc = 32'h41;
`else
    mem[0] = 32'h0010_0093; mem[1] = 32'h0020_0113;
    do_reset();
    repeat (2) @(negedge clk);
    redirect_pc = 32'h43;
`endif
    stall = 1'b1; redirect = 1'b1;
    @(negedge clk);
    redirect = 1'b0; stall = 1'b0;
    checks++;
    if (instr_valid !== 1'b0) begin
      failures++; $display("FAIL redir_valid0 got=%b exp=0", instr_valid);
    end
    checks++;
    if (imem_addr !== 9'd16) begin
      failures++; $display("FAIL redir_addr got=%0d exp=16", imem_addr);
    end
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b0) begin
      failures++; $display("FAIL redir_fill got=%b exp=0", instr_valid);
    end
    @(negedge clk);
    exp_v = {1'b1, 32'h0070_0393, 32'h40, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      failures++; $display("FAIL redir_target got=%h exp=%h", obs, exp_v);
    end
  endtask

`ifdef FETCH_RVC_EN
  task automatic test_rvc_pair;
    load_nops();
    mem[0] = {16'h4585, 16'h4501};
    do_reset();
    @(negedge clk);
    checks++;
    if (imem_addr !== 9'd0) begin
      failures++; $display("FAIL rvc_addr_a got=%0d exp=0", imem_addr);
    end
    @(negedge clk);
    exp_v = {1'b1, 32'h0000_4501, 32'h0, 1'b1};
    checks++;
    if (obs !== exp_v) begin
      failures++; $display("FAIL rvc_first got=%h exp=%h", obs, exp_v);
    end
    checks++;
    if (imem_addr !== 9'd0) begin
      failures++; $display("FAIL rvc_addr_b got=%0d exp=0", imem_addr);
    end
    @(negedge clk);
    exp_v = {1'b1, 32'h0000_4585, 32'h2, 1'b1};
    checks++;
    if (obs !== exp_v) begin
      failures++; $display("FAIL rvc_second got=%h exp=%h", obs, exp_v);
    end
  endtask

  task automatic test_split;
    load_nops();
    mem[0] = {16'h0093, 16'h4501}; mem[1] = {16'h4585, 16'h0050};
    do_reset();
    repeat (2) @(negedge clk);
    exp_v = {1'b1, 32'h0000_4501, 32'h0, 1'b1};
    checks++;
    if (obs !== exp_v) begin
      failures++; $display("FAIL split_rvc got=%h exp=%h", obs, exp_v);
    end
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b0) begin
      failures++; $display("FAIL split_bubble got=%b exp=0", instr_valid);
    end
    @(negedge clk);
    exp_v = {1'b1, 32'h0050_0093, 32'h2, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      failures++; $display("FAIL split_join got=%h exp=%h", obs, exp_v);
    end
    @(negedge clk);
    exp_v = {1'b1, 32'h0000_4585, 32'h6, 1'b1};
    checks++;
    if (obs !== exp_v) begin
      failures++; $display("FAIL split_after got=%h exp=%h", obs, exp_v);
    end
  endtask
`else
  task automatic test_no_rvc;
    load_nops();
    mem[0] = 32'h0000_4501; mem[1] = 32'h0010_0113;
    do_reset();
    repeat (2) @(negedge clk);
    exp_v = {1'b1, 32'h0000_4501, 32'h0, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      failures++; $display("FAIL norvc_first got=%h exp=%h", obs, exp_v);
    end
    @(negedge clk);
    exp_v = {1'b1, 32'h0010_0113, 32'h4, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      failures++; $display("FAIL norvc_second got=%h exp=%h", obs, exp_v);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    load_nops();
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
`ifdef FETCH_RVC_EN
    test_rvc_pair();
    test_split();
`else
    test_no_rvc();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
